datapath_sequencer: RTL and testbench

- Hardwired fetch/decode/execute control unit for the `system` datapath (ARF, IR, Memory, register file, muxes A/B/C, ALU with flag register).
- Drives every control input of `system`, one-to-one by name, and reads back `IR_out_MSBs` and `IR_out_LSBs`.
- Runs two fetch cycles followed by one execute cycle, with idle and halt states.

---
 rtl/datapath_sequencer.sv | 174 +++++++++++++++++
 tb/tb_datapath_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Hardwired fetch/decode/execute control unit for the `system` datapath.
// Control outputs are a combinational decode of the state register and IR bytes, forced inactive while reset is high.
module datapath_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ir_msb,
    input  logic [7:0] ir_lsb,
    output logic [1:0] outasel,
    output logic [1:0] outbsel,
    output logic [1:0] funsel_IR,
    output logic [1:0] funsel_arf,
    output logic [1:0] funsel_rf,
    output logic [3:0] funsel_alu,
    output logic [3:0] regsel_rf,
    output logic [3:0] regsel_arf,
    output logic [3:0] rf_tsel,
    output logic [2:0] rf_o1sel,
    output logic [2:0] rf_o2sel,
    output logic       wrMEM,
    output logic       csMEM,
    output logic       IR_enable,
    output logic       IR_lh,
    output logic [1:0] MUXSelA,
    output logic [1:0] MUXSelB,
    output logic       MUXSelC,
    output logic       busy,
    output logic       halted
);

    // IDLE wait start | CLR PC clear | FETCH_L/H IR byte load + PC++ | EXEC decode | HALT until reset
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        FETCH_L = 3'd2,
        FETCH_H = 3'd3,
        EXEC    = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h0, OP_LDM = 4'h1, OP_STM = 4'h2, OP_ADD = 4'h3,
                           OP_SUB = 4'h4, OP_LAR = 4'h5, OP_BRA = 4'h6, OP_INC = 4'h7,
                           OP_DEC = 4'h8, OP_HLT = 4'hF;

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic [1:0] rd, rs;
    logic [3:0] rd_onehot;
    logic [2:0] rd_idx, rs_idx;
    logic       unused_ir_lsb;

    assign opcode        = ir_msb[7:4];
    assign rd            = ir_msb[3:2];
    assign rs            = ir_msb[1:0];
    assign rd_onehot     = 4'b1000 >> rd;
    assign rd_idx        = 3'b100 + {1'b0, rd};
    assign rs_idx        = 3'b100 + {1'b0, rs};
    assign unused_ir_lsb = ^ir_lsb;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLR;
            CLR:     state_d = FETCH_L;
            FETCH_L: state_d = FETCH_H;
            FETCH_H: state_d = EXEC;
            EXEC:    state_d = (opcode == OP_HLT) ? HALT : FETCH_L;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        outasel    = 2'b00;
        outbsel    = 2'b00;
        funsel_IR  = 2'b00;
        funsel_arf = 2'b00;
        funsel_rf  = 2'b00;
        funsel_alu = 4'b0000;
        regsel_rf  = 4'b0000;
        regsel_arf = 4'b0000;
        rf_tsel    = 4'b0000;
        rf_o1sel   = 3'b000;
        rf_o2sel   = 3'b000;
        wrMEM      = 1'b0;
        csMEM      = 1'b1;
        IR_enable  = 1'b0;
        IR_lh      = 1'b0;
        MUXSelA    = 2'b00;
        MUXSelB    = 2'b00;
        MUXSelC    = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        // Gating on reset keeps every write enable low on the reset edge itself.
        if (!reset) begin
            case (state_q)
                CLR: begin
                    regsel_arf = 4'b0001;
                    if (RESET_PC != 8'h00) begin
                        MUXSelB    = 2'b10;
                        funsel_arf = 2'b01;
                    end
                end
                FETCH_L, FETCH_H: begin
                    busy       = 1'b1;
                    outbsel    = 2'b11;
                    csMEM      = 1'b0;
                    IR_enable  = 1'b1;
                    funsel_IR  = 2'b01;
                    IR_lh      = (state_q == FETCH_H);
                    regsel_arf = 4'b0001;
                    funsel_arf = 2'b11;
                end
                EXEC: begin
                    busy = 1'b1;
                    case (opcode)
                        OP_LDI: begin
                            MUXSelA   = 2'b10;
                            funsel_rf = 2'b01;
                            regsel_rf = rd_onehot;
                        end
                        OP_LDM: begin
                            csMEM     = 1'b0;
                            MUXSelA   = 2'b01;
                            funsel_rf = 2'b01;
                            regsel_rf = rd_onehot;
                        end
                        OP_STM: begin
                            rf_o1sel = rd_idx;
                            csMEM    = 1'b0;
                            wrMEM    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rf_o1sel   = rd_idx;
                            rf_o2sel   = rs_idx;
                            funsel_alu = (opcode == OP_ADD) ? 4'b0100 : 4'b0110;
                            funsel_rf  = 2'b01;
                            regsel_rf  = rd_onehot;
                        end
                        OP_LAR: begin
                            MUXSelB    = 2'b10;
                            regsel_arf = 4'b1000;
                            funsel_arf = 2'b01;
                        end
                        OP_BRA: begin
                            MUXSelB    = 2'b10;
                            regsel_arf = 4'b0001;
                            funsel_arf = 2'b01;
                        end
                        OP_INC: begin
                            funsel_rf = 2'b11;
                            regsel_rf = rd_onehot;
                        end
                        OP_DEC: begin
                            funsel_rf = 2'b10;
                            regsel_rf = rd_onehot;
                        end
                        default: ;
                    endcase
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: table of EXEC decodes plus hand-written reset/halt sequences.
module tb_datapath_sequencer;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [7:0] ir_msb, ir_lsb;
    logic [1:0] outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, MUXSelA, MUXSelB;
    logic [3:0] funsel_alu, regsel_rf, regsel_arf, rf_tsel;
    logic [2:0] rf_o1sel, rf_o2sel;
    logic       wrMEM, csMEM, IR_enable, IR_lh, MUXSelC, busy, halted;

    typedef struct packed {
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] funsel_IR;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] funsel_alu;
        logic [3:0] regsel_rf;
        logic [3:0] regsel_arf;
        logic [3:0] rf_tsel;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic       wrMEM;
        logic       csMEM;
        logic       IR_enable;
        logic       IR_lh;
        logic [1:0] MUXSelA;
        logic [1:0] MUXSelB;
        logic       MUXSelC;
        logic       busy;
        logic       halted;
    } ctl_t;

    typedef struct {
        string      name;
        logic [7:0] msb;
        logic [7:0] lsb;
        ctl_t       exp;
    } vec_t;

    ctl_t act;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_cycles = 0;
    vec_t vecs[14];

    datapath_sequencer #(.RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset), .start(start), .ir_msb(ir_msb), .ir_lsb(ir_lsb),
        .outasel(outasel), .outbsel(outbsel), .funsel_IR(funsel_IR), .funsel_arf(funsel_arf),
        .funsel_rf(funsel_rf), .funsel_alu(funsel_alu), .regsel_rf(regsel_rf),
        .regsel_arf(regsel_arf), .rf_tsel(rf_tsel), .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel),
        .wrMEM(wrMEM), .csMEM(csMEM), .IR_enable(IR_enable), .IR_lh(IR_lh),
        .MUXSelA(MUXSelA), .MUXSelB(MUXSelB), .MUXSelC(MUXSelC), .busy(busy), .halted(halted)
    );

    assign act = {outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu, regsel_rf,
                  regsel_arf, rf_tsel, rf_o1sel, rf_o2sel, wrMEM, csMEM, IR_enable, IR_lh,
                  MUXSelA, MUXSelB, MUXSelC, busy, halted};

    always #5 clock = ~clock;

    always @(negedge clock) if (wrMEM === 1'b1) wr_cycles++;

    function automatic ctl_t inactive();
        ctl_t c = '0;
        c.csMEM = 1'b1;
        return c;
    endfunction

    function automatic ctl_t exec_base();
        ctl_t c = inactive();
        c.busy = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fetch_exp(input logic hi);
        ctl_t c = inactive();
        c.busy       = 1'b1;
        c.outbsel    = 2'b11;
        c.csMEM      = 1'b0;
        c.IR_enable  = 1'b1;
        c.funsel_IR  = 2'b01;
        c.IR_lh      = hi;
        c.regsel_arf = 4'b0001;
        c.funsel_arf = 2'b11;
        return c;
    endfunction

    task automatic check(input string nm, input ctl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_vec(input int i, input string nm, input logic [7:0] m, input logic [7:0] l, input ctl_t e);
        vecs[i].name = nm;
        vecs[i].msb  = m;
        vecs[i].lsb  = l;
        vecs[i].exp  = e;
    endtask

    // Runs IDLE -> CLR -> FETCH_L -> FETCH_H, leaving the DUT in EXEC.
    task automatic start_to_exec(input string tag);
        ctl_t e;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = inactive();
        e.regsel_arf = 4'b0001;
        check({tag, "_clr"}, e);
        tick();
        check({tag, "_fetch_l"}, fetch_exp(1'b0));
        tick();
        check({tag, "_fetch_h"}, fetch_exp(1'b1));
        tick();
    endtask

    initial begin
        ctl_t e;

        e = exec_base(); e.MUXSelA = 2'b10; e.funsel_rf = 2'b01; e.regsel_rf = 4'b1000;
        set_vec(0, "ldi_r1", 8'h00, 8'h2A, e);
        e = exec_base(); e.MUXSelA = 2'b10; e.funsel_rf = 2'b01; e.regsel_rf = 4'b0100;
        set_vec(1, "ldi_r2", 8'h04, 8'h03, e);
        e = exec_base(); e.rf_o1sel = 3'b100; e.rf_o2sel = 3'b101; e.funsel_alu = 4'b0100;
        e.funsel_rf = 2'b01; e.regsel_rf = 4'b1000;
        set_vec(2, "add_r1_r2", 8'h31, 8'h00, e);
        e = exec_base(); e.rf_o1sel = 3'b100; e.rf_o2sel = 3'b101; e.funsel_alu = 4'b0110;
        e.funsel_rf = 2'b01; e.regsel_rf = 4'b1000;
        set_vec(3, "sub_r1_r2", 8'h41, 8'h00, e);
        e = exec_base(); e.MUXSelB = 2'b10; e.regsel_arf = 4'b1000; e.funsel_arf = 2'b01;
        set_vec(4, "lar_80", 8'h50, 8'h80, e);
        e = exec_base(); e.MUXSelA = 2'b10; e.funsel_rf = 2'b01; e.regsel_rf = 4'b0010;
        set_vec(5, "ldi_r3", 8'h08, 8'h55, e);
        e = exec_base(); e.rf_o1sel = 3'b110; e.csMEM = 1'b0; e.wrMEM = 1'b1;
        set_vec(6, "stm_r3", 8'h28, 8'h00, e);
        e = exec_base(); e.csMEM = 1'b0; e.MUXSelA = 2'b01; e.funsel_rf = 2'b01; e.regsel_rf = 4'b0001;
        set_vec(7, "ldm_r4", 8'h1C, 8'h00, e);
        e = exec_base(); e.rf_o1sel = 3'b111; e.rf_o2sel = 3'b110; e.funsel_alu = 4'b0100;
        e.funsel_rf = 2'b01; e.regsel_rf = 4'b0001;
        set_vec(8, "add_r4_r3", 8'h3E, 8'h00, e);
        e = exec_base(); e.funsel_rf = 2'b11; e.regsel_rf = 4'b0100;
        set_vec(9, "inc_r2", 8'h74, 8'h00, e);
        e = exec_base(); e.funsel_rf = 2'b10; e.regsel_rf = 4'b0001;
        set_vec(10, "dec_r4", 8'h8C, 8'h00, e);
        e = exec_base(); e.MUXSelB = 2'b10; e.regsel_arf = 4'b0001; e.funsel_arf = 2'b01;
        set_vec(11, "bra_10", 8'h60, 8'h10, e);
        set_vec(12, "nop_9", 8'h9F, 8'hFF, exec_base());
        set_vec(13, "nop_e", 8'hEF, 8'h00, exec_base());

        reset = 1'b1; start = 1'b0; ir_msb = 8'h00; ir_lsb = 8'h00;
        repeat (3) tick();
        check("reset_inactive", inactive());
        start = 1'b1;
        tick();
        check("start_under_reset", inactive());
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("idle", inactive());
        tick();
        check("idle_hold", inactive());
        start = 1'b1;
        #1;
        check("start_no_comb_path", inactive());
        tick();
        start = 1'b0;
        e = inactive(); e.regsel_arf = 4'b0001;
        check("clr", e);
        tick();

        for (int i = 0; i < 14; i++) begin
            check({vecs[i].name, "_fetch_l"}, fetch_exp(1'b0));
            tick();
            check({vecs[i].name, "_fetch_h"}, fetch_exp(1'b1));
            tick();
            ir_msb = vecs[i].msb;
            ir_lsb = vecs[i].lsb;
            #1;
            check(vecs[i].name, vecs[i].exp);
            tick();
        end

        check("hlt_fetch_l", fetch_exp(1'b0));
        tick();
        check("hlt_fetch_h", fetch_exp(1'b1));
        tick();
        ir_msb = 8'hF0;
        #1;
        check("hlt_exec", exec_base());
        tick();
        e = inactive(); e.halted = 1'b1;
        check("halted", e);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("halt_ignores_start", e);
            tick();
            check("halt_hold", e);
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_halt", inactive());
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_fetch_h", fetch_exp(1'b1));
        reset = 1'b1;
        #1;
        check("reset_in_fetch_h", inactive());
        tick();
        reset = 1'b0;
        #1;
        check("idle_after_fetch_reset", inactive());
        tick();
        check("idle_stays", inactive());

        start_to_exec("stm_abort");
        ir_msb = 8'h28;
        reset = 1'b1;
        #1;
        check("reset_in_stm_exec", inactive());
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_stm_reset", inactive());

        start_to_exec("wrap");
        ir_msb = 8'h00;
        #1;
        check("wrap_exec_ldi", vecs[0].exp);
        tick();
        check("wrap_next_fetch", fetch_exp(1'b0));

        n_checks++;
        if (wr_cycles != 1) begin
            n_fail++;
            $display("FAIL wr_once: got %0d wrMEM cycles expected 1", wr_cycles);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
